// File: rtl/spi_pkg.sv
// Shared SPI definitions for the BKP slave and master endpoints.
package spi_pkg;

   localparam int unsigned SPI_BYTE_W = 8;

   // SPI modes as {CPOL, CPHA}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2
   } spi_state_e;

   typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

endpackage

// File: rtl/spi_slave_bkp_if.sv
// BKP byte bus between the SPI slave endpoint and its host.
interface spi_slave_bkp_if;
   import spi_pkg::*;

   spi_byte_t bkp_data_i;
   logic      bkp_ready_i;
   logic      bkp_busy_o;
   spi_byte_t bkp_data_o;
   logic      bkp_ready_o;

   modport slave  (input  bkp_data_i, bkp_ready_i,
                   output bkp_busy_o, bkp_data_o, bkp_ready_o);
   modport master (output bkp_data_i, bkp_ready_i,
                   input  bkp_busy_o, bkp_data_o, bkp_ready_o);

endinterface

// File: rtl/spi_slave_txfifo.sv
// Synchronous TX byte FIFO; DEPTH must be a power of two.
module spi_slave_txfifo
   import spi_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   parameter  int unsigned W     = SPI_BYTE_W,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     wdata,
   output logic [W-1:0]     rdata_c,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count_d;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && (count != '0);
   assign rdata_c = mem[rd_ptr];

   always_comb begin
      count_d = count;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count + CNT_W'(1);
         2'b01:   count_d = count - CNT_W'(1);
         default: count_d = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count_d;
         full  <= (count_d == CNT_W'(DEPTH));
      end
   end

endmodule

// File: rtl/spi_slave_bkp.sv
// SPI slave endpoint for the BKP byte bus, oversampling SCK/SS/MOSI in clk.
// Optional LSB-first shifting is enabled by defining SPI_SLAVE_LSB_FIRST_EN.
module spi_slave_bkp
   import spi_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned TX_DEPTH    = 2,
   parameter spi_byte_t   IDLE_FILL   = 8'h00
) (
   input  logic clk,
   input  logic rst_n,
   input  logic DESR,
   input  logic CPOL,
   input  logic CPHA,
   input  logic SCK_i,
   input  logic SS_i,
   input  logic MOSI_i,
`ifdef SPI_SLAVE_LSB_FIRST_EN
   input  logic lsb_first,
`endif
   output logic MISO_o,
   output logic MISO_oe,
   output logic frame_active_o,
   output logic tx_underrun_o,
   spi_slave_bkp_if.slave bus
);

   localparam int unsigned LAST  = SYNC_STAGES - 1;
   localparam int unsigned PREV  = SYNC_STAGES - 2;
   localparam int unsigned BIT_W = $clog2(SPI_BYTE_W);
   localparam int unsigned CNT_W = $clog2(TX_DEPTH + 1);

   logic srst;
   logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
   logic sck_rise, sck_fall, sample_edge, shift_edge, ss_fall, ss_rise, mosi_bit;

   spi_state_e       state_q, state_d;
   spi_byte_t        tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_next, tx_shift;
   spi_byte_t        data_q, data_d, load_byte;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic byte_done_q, byte_done_d, first_q, first_d, fill_pend_q, fill_pend_d;
   logic oe_q, oe_d, miso_q, miso_d, ready_q, ready_d, underrun_q, underrun_d, tx_bit;

   logic             pop_c;
   logic             fifo_full;
   logic             fifo_empty;
   spi_byte_t        fifo_head;
   logic [CNT_W-1:0] fifo_count;

   assign srst = !rst_n || !DESR;

   // Input synchronisers; SS presets inactive, SCK presets to its idle level
   always_ff @(posedge clk) begin
      if (srst) begin
         sck_q  <= {SYNC_STAGES{CPOL}};
         ss_q   <= '1;
         mosi_q <= '0;
      end else begin
         sck_q  <= {sck_q[PREV:0], SCK_i};
         ss_q   <= {ss_q[PREV:0], SS_i};
         mosi_q <= {mosi_q[PREV:0], MOSI_i};
      end
   end

   assign sck_rise    =  sck_q[PREV] & ~sck_q[LAST];
   assign sck_fall    = ~sck_q[PREV] &  sck_q[LAST];
   assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
   assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;
   assign ss_fall     = ~ss_q[PREV] &  ss_q[LAST];
   assign ss_rise     =  ss_q[PREV] & ~ss_q[LAST];
   assign mosi_bit    = mosi_q[LAST];

   spi_slave_txfifo #(.DEPTH(TX_DEPTH), .W(SPI_BYTE_W)) u_txfifo (
      .clk     (clk),
      .clr     (srst),
      .push    (bus.bkp_ready_i),
      .pop     (pop_c),
      .wdata   (bus.bkp_data_i),
      .rdata_c (fifo_head),
      .full    (fifo_full),
      .count   (fifo_count)
   );

   assign fifo_empty = (fifo_count == '0);
   assign load_byte  = fifo_empty ? IDLE_FILL : fifo_head;

`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign rx_next  = lsb_first ? {mosi_bit, rx_sr_q[SPI_BYTE_W-1:1]}
                               : {rx_sr_q[SPI_BYTE_W-2:0], mosi_bit};
   assign tx_shift = lsb_first ? (tx_sr_q >> 1) : (tx_sr_q << 1);
   assign tx_bit   = lsb_first ? tx_sr_d[0] : tx_sr_d[SPI_BYTE_W-1];
`else
   assign rx_next  = {rx_sr_q[SPI_BYTE_W-2:0], mosi_bit};
   assign tx_shift = tx_sr_q << 1;
   assign tx_bit   = tx_sr_d[SPI_BYTE_W-1];
`endif

   // Next-state and datapath update
   always_comb begin
      state_d     = state_q;
      tx_sr_d     = tx_sr_q;
      rx_sr_d     = rx_sr_q;
      bit_cnt_d   = bit_cnt_q;
      byte_done_d = byte_done_q;
      first_d     = first_q;
      fill_pend_d = fill_pend_q;
      oe_d        = oe_q;
      data_d      = data_q;
      ready_d     = 1'b0;
      underrun_d  = underrun_q;
      pop_c       = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            oe_d = 1'b0;
            if (ss_fall) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pop_c       = !fifo_empty;
            tx_sr_d     = load_byte;
            underrun_d  = underrun_q | fifo_empty;
            rx_sr_d     = '0;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
            first_d     = 1'b1;
            fill_pend_d = 1'b0;
            oe_d        = 1'b1;
            state_d     = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (sample_edge) begin
               rx_sr_d   = rx_next;
               bit_cnt_d = bit_cnt_q + BIT_W'(1);
               // A fill byte only counts as an underrun once the master clocks it
               if (fill_pend_q) begin
                  underrun_d  = 1'b1;
                  fill_pend_d = 1'b0;
               end
               if (bit_cnt_q == BIT_W'(SPI_BYTE_W - 1)) begin
                  data_d      = rx_next;
                  ready_d     = 1'b1;
                  byte_done_d = 1'b1;
               end
            end
            if (shift_edge) begin
               first_d = 1'b0;
               if (CPHA && first_q) begin
                  tx_sr_d = tx_sr_q;
               end else if (byte_done_q) begin
                  pop_c       = !fifo_empty;
                  tx_sr_d     = load_byte;
                  fill_pend_d = fifo_empty;
                  byte_done_d = 1'b0;
               end else begin
                  tx_sr_d = tx_shift;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (ss_rise) begin
         state_d     = ST_IDLE;
         oe_d        = 1'b0;
         bit_cnt_d   = '0;
         byte_done_d = 1'b0;
         fill_pend_d = 1'b0;
      end

      miso_d = oe_d & tx_bit;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= ST_IDLE;
         tx_sr_q     <= '0;
         rx_sr_q     <= '0;
         bit_cnt_q   <= '0;
         byte_done_q <= 1'b0;
         first_q     <= 1'b0;
         fill_pend_q <= 1'b0;
         oe_q        <= 1'b0;
         miso_q      <= 1'b0;
         data_q      <= '0;
         ready_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_sr_q     <= tx_sr_d;
         rx_sr_q     <= rx_sr_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_done_q <= byte_done_d;
         first_q     <= first_d;
         fill_pend_q <= fill_pend_d;
         oe_q        <= oe_d;
         miso_q      <= miso_d;
         data_q      <= data_d;
         ready_q     <= ready_d;
         underrun_q  <= underrun_d;
      end
   end

   assign MISO_o          = miso_q;
   assign MISO_oe         = oe_q;
   assign frame_active_o  = ~ss_q[LAST];
   assign tx_underrun_o   = underrun_q;
   assign bus.bkp_busy_o  = fifo_full;
   assign bus.bkp_data_o  = data_q;
   assign bus.bkp_ready_o = ready_q;

endmodule
